// File: rtl/slot_alloc_32.sv
// Lowest-index-first allocator for 32 tracked entries: busy bitmap, one grant and one release per cycle, full flush.
// Includes the first-one isolation, 32-to-5 encoder and 5-to-32 decoder primitives it is built from.

module PrioIsolate32 (
  input  logic [31:0] i_vec,
  output logic [31:0] o_first
);
  assign o_first = i_vec & (~i_vec + 32'd1);
endmodule

module Enc32To5 (
  input  logic [31:0] i_oh,
  output logic [4:0]  o_idx
);
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (i_oh[i]) o_idx = o_idx | 5'(i);
    end
  end
endmodule

module Dec5To32 (
  input  logic [4:0]  i_idx,
  output logic [31:0] o_oh
);
  assign o_oh = 32'd1 << i_idx;
endmodule

module slot_alloc_32 (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_alloc_req,
  output logic        o_alloc_ready,
  output logic [4:0]  o_alloc_idx,
  output logic [31:0] o_alloc_oh,
  input  logic        i_free_valid,
  input  logic [4:0]  i_free_idx,
  input  logic        i_flush,
  output logic [31:0] o_busy_vec,
  output logic [5:0]  o_used_cnt,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_dbl_free_err
);

  logic [31:0] r_busyVec;
  logic [5:0]  r_usedCnt;
  logic        r_dblFreeErr;

  logic [31:0] w_freeVec;
  logic [31:0] w_firstFree;
  logic [4:0]  w_allocIdx;
  logic [31:0] w_allocDec;
  logic [31:0] w_freeDec;
  logic        w_allocReady;
  logic        w_allocFire;
  logic        w_freeHit;
  logic        w_freeEff;
  logic        w_freeBad;
  logic [31:0] w_busyNext;
  logic [5:0]  w_cntNext;

  assign w_freeVec    = ~r_busyVec;
  assign w_allocReady = |w_freeVec;

  PrioIsolate32 uIsolate (.i_vec(w_freeVec), .o_first(w_firstFree));
  Enc32To5      uEnc     (.i_oh(w_firstFree), .o_idx(w_allocIdx));
  Dec5To32      uDecAlloc(.i_idx(w_allocIdx), .o_oh(w_allocDec));
  Dec5To32      uDecFree (.i_idx(i_free_idx), .o_oh(w_freeDec));

  assign w_allocFire = i_alloc_req & w_allocReady;
  assign w_freeHit   = |(r_busyVec & w_freeDec);
  assign w_freeEff   = i_free_valid & w_freeHit;
  assign w_freeBad   = i_free_valid & ~w_freeHit;

  // An effective release always targets a busy entry, so it never collides with the granted (free) entry.
  assign w_busyNext = (r_busyVec | (w_allocFire ? w_allocDec : 32'd0))
                    & ~(w_freeEff ? w_freeDec : 32'd0);

  always_comb begin
    w_cntNext = r_usedCnt;
    if (w_allocFire && !w_freeEff)      w_cntNext = r_usedCnt + 6'd1;
    else if (!w_allocFire && w_freeEff) w_cntNext = r_usedCnt - 6'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_busyVec    <= '0;
      r_usedCnt    <= '0;
      r_dblFreeErr <= 1'b0;
    end else begin
      r_busyVec    <= w_busyNext;
      r_usedCnt    <= w_cntNext;
      r_dblFreeErr <= r_dblFreeErr | w_freeBad;
    end
  end

  assign o_alloc_ready  = w_allocReady;
  assign o_alloc_idx    = w_allocIdx;
  assign o_alloc_oh     = w_allocReady ? w_allocDec : 32'd0;
  assign o_busy_vec     = r_busyVec;
  assign o_used_cnt     = r_usedCnt;
  assign o_full         = (r_usedCnt == 6'd32);
  assign o_empty        = (r_usedCnt == 6'd0);
  assign o_dbl_free_err = r_dblFreeErr;

endmodule

// File: tb/tb_slot_alloc_32.sv
// Self-checking bench for slot_alloc_32: directed vector table, hand-written corner sequences, and
// a randomized run compared against an array-based model of the allocator rules.

module tb_slot_alloc_32;

  logic        clk = 1'b0;
  logic        rst, allocReq, freeValid, flush;
  logic [4:0]  freeIdx;
  logic        allocReady, full, empty, dblFreeErr;
  logic [4:0]  allocIdx;
  logic [31:0] allocOh, busyVec;
  logic [5:0]  usedCnt;

  int vectors = 0;
  int miscompares = 0;

  bit mBusy[32];
  bit mErr;

  typedef struct {
    logic        rst;
    logic        req;
    logic        fv;
    logic [4:0]  fidx;
    logic        fl;
    logic [31:0] expBusy;
    int          expCnt;
    int          expIdx;
    logic        expErr;
  } vec_t;

  vec_t tbl[13];

  always #5 clk = ~clk;

  slot_alloc_32 dut (
    .i_clk(clk), .i_rst(rst), .i_alloc_req(allocReq),
    .o_alloc_ready(allocReady), .o_alloc_idx(allocIdx), .o_alloc_oh(allocOh),
    .i_free_valid(freeValid), .i_free_idx(freeIdx), .i_flush(flush),
    .o_busy_vec(busyVec), .o_used_cnt(usedCnt), .o_full(full), .o_empty(empty),
    .o_dbl_free_err(dblFreeErr)
  );

  function automatic int modelCount();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(mBusy[i]);
    return n;
  endfunction

  function automatic int modelLowest();
    for (int i = 0; i < 32; i++) if (!mBusy[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] modelVec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = mBusy[i];
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, let the edge pass, and advance the model by the same rules.
  task automatic applyStimulus(input logic r, input logic req, input logic fv,
                               input logic [4:0] fidx, input logic fl);
    int  low;
    bit  anyFree;
    bit  hit;
    rst = r; allocReq = req; freeValid = fv; freeIdx = fidx; flush = fl;
    anyFree = (modelCount() < 32);
    low = modelLowest();
    hit = mBusy[fidx];
    @(posedge clk);
    #1;
    if (r || fl) begin
      foreach (mBusy[i]) mBusy[i] = 1'b0;
      mErr = 1'b0;
    end else begin
      if (fv) begin
        if (hit) mBusy[fidx] = 1'b0;
        else     mErr = 1'b1;
      end
      if (req && anyFree) mBusy[low] = 1'b1;
    end
    rst = 0; allocReq = 0; freeValid = 0; freeIdx = 0; flush = 0;
  endtask

  task automatic checkOutput(input string tag);
    int cnt = modelCount();
    checkVal({tag, ":busy"},  busyVec, modelVec());
    checkVal({tag, ":cnt"},   32'(usedCnt), 32'(cnt));
    checkVal({tag, ":pop"},   32'(usedCnt), 32'($countones(busyVec)));
    checkVal({tag, ":ready"}, 32'(allocReady), 32'(cnt < 32));
    checkVal({tag, ":idx"},   32'(allocIdx), 32'(modelLowest()));
    checkVal({tag, ":oh"},    allocOh, (cnt < 32) ? (32'd1 << modelLowest()) : 32'd0);
    checkVal({tag, ":full"},  32'(full), 32'(cnt == 32));
    checkVal({tag, ":empty"}, 32'(empty), 32'(cnt == 0));
    checkVal({tag, ":err"},   32'(dblFreeErr), 32'(mErr));
  endtask

  initial begin
    logic [31:0] expB;
    rst = 1; allocReq = 0; freeValid = 0; freeIdx = 0; flush = 0;
    mErr = 0;
    foreach (mBusy[i]) mBusy[i] = 1'b0;

    //         rst req fv fidx fl  expBusy      cnt idx err
    tbl[0]  = '{0, 1, 0, 5'd0, 0, 32'h1,       1,  1,  0};
    tbl[1]  = '{0, 0, 1, 5'd5, 0, 32'h1,       1,  1,  1};
    tbl[2]  = '{0, 1, 1, 5'd1, 0, 32'h3,       2,  2,  1};
    tbl[3]  = '{0, 0, 1, 5'd0, 0, 32'h2,       1,  0,  1};
    tbl[4]  = '{0, 1, 1, 5'd1, 0, 32'h1,       1,  1,  1};
    tbl[5]  = '{0, 1, 1, 5'd0, 1, 32'h0,       0,  0,  0};
    tbl[6]  = '{0, 1, 0, 5'd0, 0, 32'h1,       1,  1,  0};
    tbl[7]  = '{0, 1, 0, 5'd0, 0, 32'h3,       2,  2,  0};
    tbl[8]  = '{0, 0, 1, 5'd0, 0, 32'h2,       1,  0,  0};
    tbl[9]  = '{0, 1, 1, 5'd1, 0, 32'h1,       1,  1,  0};
    tbl[10] = '{0, 0, 1, 5'd0, 1, 32'h0,       0,  0,  0};
    tbl[11] = '{0, 1, 0, 5'd0, 0, 32'h1,       1,  1,  0};
    tbl[12] = '{1, 1, 1, 5'd0, 1, 32'h0,       0,  0,  0};

    applyStimulus(1, 0, 0, 0, 0);
    checkVal("rst:busy", busyVec, 32'h0);
    checkVal("rst:cnt", 32'(usedCnt), 32'd0);
    checkVal("rst:err", 32'(dblFreeErr), 32'd0);
    checkVal("rst:ready", 32'(allocReady), 32'd1);
    checkVal("rst:idx", 32'(allocIdx), 32'd0);
    checkVal("rst:oh", allocOh, 32'h1);
    checkVal("rst:empty", 32'(empty), 32'd1);
    checkVal("rst:full", 32'(full), 32'd0);

    for (int v = 0; v < 13; v++) begin
      applyStimulus(tbl[v].rst, tbl[v].req, tbl[v].fv, tbl[v].fidx, tbl[v].fl);
      checkVal($sformatf("tbl%0d:busy", v), busyVec, tbl[v].expBusy);
      checkVal($sformatf("tbl%0d:cnt", v), 32'(usedCnt), 32'(tbl[v].expCnt));
      checkVal($sformatf("tbl%0d:idx", v), 32'(allocIdx), 32'(tbl[v].expIdx));
      checkVal($sformatf("tbl%0d:oh", v), allocOh, 32'd1 << tbl[v].expIdx);
      checkVal($sformatf("tbl%0d:err", v), 32'(dblFreeErr), 32'(tbl[v].expErr));
    end

    // Fill from empty: grants must come out in index order.
    for (int i = 0; i < 32; i++) begin
      checkVal($sformatf("fill%0d:idx", i), 32'(allocIdx), 32'(i));
      applyStimulus(0, 1, 0, 0, 0);
      expB = 32'((64'd1 << (i + 1)) - 64'd1);
      checkVal($sformatf("fill%0d:cnt", i), 32'(usedCnt), 32'(i + 1));
      checkVal($sformatf("fill%0d:busy", i), busyVec, expB);
    end
    checkVal("full:full", 32'(full), 32'd1);
    checkVal("full:ready", 32'(allocReady), 32'd0);
    checkVal("full:oh", allocOh, 32'h0);
    checkVal("full:idx", 32'(allocIdx), 32'd0);
    applyStimulus(0, 1, 0, 0, 0);
    checkVal("full33:busy", busyVec, 32'hFFFF_FFFF);
    checkVal("full33:cnt", 32'(usedCnt), 32'd32);

    applyStimulus(0, 0, 1, 5'd7, 0);
    checkVal("free7:idx", 32'(allocIdx), 32'd7);
    checkVal("free7:cnt", 32'(usedCnt), 32'd31);
    checkVal("free7:ready", 32'(allocReady), 32'd1);
    applyStimulus(0, 1, 0, 0, 0);
    checkVal("regrant7:cnt", 32'(usedCnt), 32'd32);
    checkVal("regrant7:full", 32'(full), 32'd1);

    // Full with alloc and free together: only the free lands.
    applyStimulus(0, 1, 1, 5'd12, 0);
    checkVal("fullAF:busy", busyVec, ~(32'd1 << 12));
    checkVal("fullAF:cnt", 32'(usedCnt), 32'd31);
    checkVal("fullAF:idx", 32'(allocIdx), 32'd12);

    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 0, 0);
    checkVal("b10:busy", busyVec, 32'h3FF);
    applyStimulus(0, 1, 1, 5'd3, 0);
    checkVal("af3:busy", busyVec, 32'h7F7);
    checkVal("af3:cnt", 32'(usedCnt), 32'd10);
    checkVal("af3:idx", 32'(allocIdx), 32'd3);

    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 5'd25, 0);
    checkVal("b20:err", 32'(dblFreeErr), 32'd1);
    checkVal("b20:cnt", 32'(usedCnt), 32'd20);
    applyStimulus(0, 1, 1, 5'd4, 1);
    checkVal("flush:busy", busyVec, 32'h0);
    checkVal("flush:cnt", 32'(usedCnt), 32'd0);
    checkVal("flush:empty", 32'(empty), 32'd1);
    checkVal("flush:err", 32'(dblFreeErr), 32'd0);
    checkVal("flush:idx", 32'(allocIdx), 32'd0);

    // Randomized traffic; releases mostly aimed at busy entries so the bitmap fills and drains.
    for (int c = 0; c < 10000; c++) begin
      logic r, req, fv, fl;
      logic [4:0] fidx;
      r   = ($urandom_range(0, 499) == 0);
      fl  = ($urandom_range(0, 149) == 0);
      req = ($urandom_range(0, 99) < 55);
      fv  = ($urandom_range(0, 99) < 50);
      fidx = 5'($urandom_range(0, 31));
      if (fv && $urandom_range(0, 3) != 0 && modelCount() > 0) begin
        for (int k = 0; k < 8; k++) begin
          if (!mBusy[fidx]) fidx = 5'($urandom_range(0, 31));
        end
      end
      applyStimulus(r, req, fv, fidx, fl);
      checkOutput($sformatf("rnd%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/slot_alloc_32.md
# slot_alloc_32

Lowest-index-first allocator for a 32-entry tracked resource (issue-queue slots, load/store buffer entries, physical tags). It holds a busy bitmap, presents the lowest free entry to a single allocation requester, accepts one release per cycle, and supports a full flush. Allocation index selection uses the shared priority-encoder primitives. One-hot write enables use the shared 5-to-32 decoder primitive.

## Interface
Parameters:
- None. Entry count is fixed at 32; index width is fixed at 5.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `alloc_req`  in  1  requester wants one entry this cycle.
- `alloc_ready`  out  1  at least one entry is free (combinational from state).
- `alloc_idx`  out  5  lowest-numbered free entry; 0 when none free.
- `alloc_oh`  out  32  one-hot of `alloc_idx`, gated by `alloc_ready`; all-zero when none free.
- `free_valid`  in  1  release one entry this cycle.
- `free_idx`  in  5  entry to release.
- `flush`  in  1  release all entries.
- `busy_vec`  out  32  registered busy bitmap.
- `used_cnt`  out  6  registered count of busy entries, 0..32.
- `full`  out  1  `used_cnt == 32`.
- `empty`  out  1  `used_cnt == 0`.
- `dbl_free_err`  out  1  sticky; set when a release targets an entry that is not busy.

## Operation
- State: `busy[31:0]`, `used_cnt[5:0]`, `dbl_free_err`.
- Fire: `alloc_fire = alloc_req & alloc_ready`.
- Selection:
  - Free vector is `~busy`.
  - `alloc_idx` is the index of its lowest set bit, using first-one isolation followed by a 32-to-5 encode.
  - `alloc_oh` is `decode(alloc_idx)` gated by `alloc_ready`.
- Allocate: on `alloc_fire`, `busy[alloc_idx]` is set at the next edge.
- Free:
  - A release is effective when `free_valid & busy[free_idx]`.
  - An effective release clears `busy[free_idx]` at the next edge.
- Count update:
  - `used_cnt` next = `used_cnt + alloc_fire - effective_free`.
  - Simultaneous alloc and effective free leaves the count unchanged.
- Invalid release:
  - A release with `busy[free_idx] == 0` is a no-op on `busy` and `used_cnt`.
  - It sets `dbl_free_err`, including when `free_idx == alloc_idx` in the same cycle.
  - In that same-cycle case the alloc still fires and the entry ends up busy.
- Flush:
  - `flush` clears `busy` to 0 and `used_cnt` to 0.
  - It overrides `alloc_fire` and `free_valid` in the same cycle; a firing alloc that cycle is discarded.
  - It also clears `dbl_free_err`.
  - The requester must treat any alloc granted in a flush cycle as cancelled.
- Priority, highest first: `rst` > `flush` > {alloc, free} (independent).
- Invariant: `used_cnt == popcount(busy)` every cycle. Verification checks this with an assertion; no popcount is built in RTL.

## Timing
- Reset values:
  - `busy_vec` = 0, `used_cnt` = 0, `dbl_free_err` = 0.
  - Consequently `alloc_ready` = 1, `alloc_idx` = 0, `alloc_oh` = 32'h1, `empty` = 1, `full` = 0.
- Visibility of state changes:
  - `alloc_ready`, `alloc_idx`, `alloc_oh` are combinational from registered `busy`; there is no input-to-output combinational path.
  - An allocated entry appears in `busy_vec` one cycle after fire. The next cycle presents the next-lowest free index.
  - A freed entry is allocatable from the cycle after the release. There is no same-cycle free-to-alloc bypass.
- Boundaries:
  - Full: `alloc_ready` = 0, and `alloc_req` is ignored with no state change.
  - Full with alloc and free together: the free takes effect and the alloc is not granted that cycle.
- Throughput: one alloc plus one free per cycle, sustained.
- Reset mid-operation: next state is exactly the reset state regardless of other inputs.

## Test plan
- Reset, then `alloc_req` held for 32 cycles:
  - Grants indices 0,1,…,31 in order.
  - `used_cnt` steps 1..32.
  - `full` = 1 after the 32nd grant; the 33rd cycle has `alloc_ready` = 0 and no state change.
- From full, free index 7, then request:
  - `alloc_idx` = 7 one cycle after the free; the grant restores `used_cnt` = 32.
- Busy = {0..9}:
  - Same-cycle alloc and free of 3 → entry 10 granted, entry 3 cleared, `used_cnt` stays 10.
  - Next `alloc_idx` = 3.
- Busy = {0}:
  - Free index 5 → `dbl_free_err` = 1, `busy_vec` unchanged, `used_cnt` = 1.
  - Same-cycle free 1 with alloc (`alloc_idx` = 1) → entry 1 busy, error set.
- Busy = 20 entries; `flush` together with `alloc_req` and `free_valid` (idx 4):
  - Next cycle `busy_vec` = 0, `used_cnt` = 0, `empty` = 1, `dbl_free_err` = 0, `alloc_idx` = 0.
- Random alloc/free/flush for 10k cycles with `rst` pulses inserted:
  - Scoreboard matches `busy_vec`.
  - `used_cnt == popcount(busy_vec)`.
  - `alloc_idx` is always the lowest zero of `busy_vec`.
